// File: rtl/add_pkg.sv
// Shared constants and state encoding for the adder-result accumulator.
package add_pkg;

  localparam int ACC_W_DEF = 12;
  localparam int CNT_W_DEF = 9;
  localparam int BEAT_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/add_accum.sv
// Accumulates a frame of 5-bit adder results ({carry,out}) into a wrapping sum
// and presents total, beat count and sticky overflow over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start with a non-zero frame length
// ACCUM | accepting beats until the latched length is reached
// HOLD  | result presented, waiting for acc_ready
module add_accum
  import add_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_carry,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_sum,
  output logic [CNT_W-1:0] acc_count,
  output logic             acc_ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   beat_ext;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign beat_ext = {{(ACC_W + 1 - BEAT_W){1'b0}}, in_carry, in_sum};
  // Extra top bit of the sum is the carry-out of the accumulator MSB.
  assign sum_ext  = {1'b0, acc_q} + beat_ext;
  assign cnt_inc  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          len_d   = frame_len;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == ACCUM);
  assign acc_valid = (state_q == HOLD);
  assign busy      = (state_q == ACCUM) || (state_q == HOLD);
  assign acc_sum   = acc_q;
  assign acc_count = cnt_q;
  assign acc_ovf   = ovf_q;

endmodule
